// File: rtl/dn_loader_if.sv
// Download bus between hps_io's ioctl port, the loader and the core write port.
// The loader sits on the slave side; hps_io and the core together form the master side.
interface dn_loader_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic        dn_valid;
    logic        dn_ready;
    logic [1:0]  dn_target;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, dn_ready,
        input  ioctl_wait, dn_valid, dn_target, dn_addr, dn_data
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, dn_ready,
        output ioctl_wait, dn_valid, dn_target, dn_addr, dn_data
    );
endinterface

// File: rtl/dn_loader.sv
// Routes downloaded bytes to the BIOS, sprite or music region with valid/ready
// back-pressure, tracks errors and byte count, and stretches the core reset after a BIOS load.
module dn_loader #(
    parameter int BIOS_AW    = 16,
    parameter int SPR_AW     = 14,
    parameter int MUS_AW     = 17,
    parameter int RESET_HOLD = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    dn_loader_if.slave  io,
    output logic        core_reset,
    output logic        done,
    output logic [7:0]  done_index,
    output logic [17:0] bytes_loaded,
    output logic        range_err,
    output logic        overrun_err
);
    localparam int CNT_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD + 1) : 1;

    localparam logic [1:0] T_BIOS = 2'd0;
    localparam logic [1:0] T_SPR  = 2'd1;
    localparam logic [1:0] T_MUS  = 2'd2;
    localparam logic [1:0] T_NONE = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_PEND, S_FLUSH, S_HOLD} state_t;

    state_t             state, nxt;
    logic               download_p1;
    logic [1:0]         tgt_p0;
    logic [1:0]         dn_target_r;
    logic [16:0]        dn_addr_r;
    logic [7:0]         dn_data_r;
    logic [CNT_W-1:0]   hold_cnt;
    logic               dl_rise;
    logic               start, take, drop_rng, overrun, accept, finish;
    logic               core_reset_nxt;
    logic [1:0]         tgt_next;

    function automatic logic [1:0] decode_target(input logic [7:0] idx);
        case (idx)
            8'd0, 8'd1: decode_target = T_BIOS;
            8'd3:       decode_target = T_SPR;
            8'd4:       decode_target = T_MUS;
            default:    decode_target = T_NONE;
        endcase
    endfunction

    function automatic logic in_range(input logic [1:0] tgt, input logic [24:0] addr);
        case (tgt)
            T_BIOS:  in_range = (addr >> BIOS_AW) == 25'd0;
            T_SPR:   in_range = (addr >> SPR_AW) == 25'd0;
            T_MUS:   in_range = (addr >> MUS_AW) == 25'd0;
            default: in_range = 1'b0;
        endcase
    endfunction

    function automatic logic [17:0] sat_inc(input logic [17:0] v);
        sat_inc = (&v) ? v : v + 18'd1;
    endfunction

    assign dl_rise = io.ioctl_download && !download_p1;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt      = state;
        start    = 1'b0;
        take     = 1'b0;
        drop_rng = 1'b0;
        overrun  = 1'b0;
        accept   = 1'b0;
        finish   = 1'b0;
        case (state)
            S_IDLE: begin
                if (dl_rise) begin
                    start = 1'b1;
                    nxt   = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (!io.ioctl_download) begin
                    finish = 1'b1;
                end else if (io.ioctl_wr) begin
                    if (tgt_p0 != T_NONE && in_range(tgt_p0, io.ioctl_addr)) begin
                        take = 1'b1;
                        nxt  = S_PEND;
                    end else if (tgt_p0 != T_NONE) begin
                        drop_rng = 1'b1;
                    end
                end
            end
            S_PEND: begin
                overrun = io.ioctl_wr;
                if (io.dn_ready) begin
                    accept = 1'b1;
                    // A close coinciding with the final acceptance finishes directly.
                    if (!io.ioctl_download) finish = 1'b1;
                    else                    nxt    = S_ACTIVE;
                end else if (!io.ioctl_download) begin
                    nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (io.dn_ready) begin
                    accept = 1'b1;
                    finish = 1'b1;
                end
            end
            S_HOLD: begin
                if (dl_rise) begin
                    start = 1'b1;
                    nxt   = S_ACTIVE;
                end else if (hold_cnt == '0) begin
                    nxt = S_IDLE;
                end
            end
            default: nxt = S_IDLE;
        endcase
        if (finish) nxt = (tgt_p0 == T_BIOS) ? S_HOLD : S_IDLE;

        tgt_next       = start ? decode_target(io.ioctl_index) : tgt_p0;
        core_reset_nxt = (nxt == S_HOLD) ||
                         ((tgt_next == T_BIOS) &&
                          (nxt == S_ACTIVE || nxt == S_PEND || nxt == S_FLUSH));
    end

    // Registered core_reset mirrors the state, so it drops one cycle after reset releases.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            download_p1  <= 1'b0;
            tgt_p0       <= T_NONE;
            dn_target_r  <= 2'd0;
            dn_addr_r    <= 17'd0;
            dn_data_r    <= 8'd0;
            hold_cnt     <= '0;
            core_reset   <= 1'b1;
            done         <= 1'b0;
            done_index   <= 8'd0;
            bytes_loaded <= 18'd0;
            range_err    <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            download_p1 <= io.ioctl_download;
            core_reset  <= core_reset_nxt;
            done        <= finish;
            if (start) begin
                tgt_p0       <= decode_target(io.ioctl_index);
                done_index   <= io.ioctl_index;
                bytes_loaded <= 18'd0;
                range_err    <= 1'b0;
                overrun_err  <= 1'b0;
            end
            if (take) begin
                dn_target_r <= tgt_p0;
                dn_addr_r   <= io.ioctl_addr[16:0];
                dn_data_r   <= io.ioctl_dout;
            end
            if (drop_rng) range_err    <= 1'b1;
            if (overrun)  overrun_err  <= 1'b1;
            if (accept)   bytes_loaded <= sat_inc(bytes_loaded);
            if (finish)
                hold_cnt <= CNT_W'(RESET_HOLD);
            else if (state == S_HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;
        end
    end

    assign io.dn_valid   = (state == S_PEND) || (state == S_FLUSH);
    assign io.ioctl_wait = (state == S_PEND) || (state == S_FLUSH);
    assign io.dn_target  = dn_target_r;
    assign io.dn_addr    = dn_addr_r;
    assign io.dn_data    = dn_data_r;
endmodule

// File: tb/tb_dn_loader.sv
// Directed bench for dn_loader: expected writes are queued when bytes are driven
// and popped by a monitor when the DUT presents an accepted write.
module tb_dn_loader;
    logic clk_sys = 1'b0;
    logic reset;
    logic        core_reset, done, range_err, overrun_err;
    logic [7:0]  done_index;
    logic [17:0] bytes_loaded;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    typedef struct {
        logic [1:0]  t;
        logic [16:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t exp_q[$];

    dn_loader_if bus ();

    dn_loader dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .io          (bus.slave),
        .core_reset  (core_reset),
        .done        (done),
        .done_index  (done_index),
        .bytes_loaded(bytes_loaded),
        .range_err   (range_err),
        .overrun_err (overrun_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] addr, input logic [7:0] data);
        bus.ioctl_addr = addr;
        bus.ioctl_dout = data;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic push(input logic [1:0] t, input logic [16:0] a, input logic [7:0] d);
        wr_t e;
        e.t = t; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    // Acceptance happens at the next rising edge whenever valid and ready are both high now.
    always @(negedge clk_sys) begin
        if (bus.dn_valid && bus.dn_ready) begin
            chk("sb_pending", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_target", {30'd0, bus.dn_target}, {30'd0, e.t});
                chk("wr_addr",   {15'd0, bus.dn_addr},   {15'd0, e.a});
                chk("wr_data",   {24'd0, bus.dn_data},   {24'd0, e.d});
            end
        end
        if (done) done_cnt++;
    end

    initial begin
        int dc;
        reset              = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.ioctl_index    = '0;
        bus.dn_ready       = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_valid",   {31'd0, bus.dn_valid},   32'd0);
        chk("rst_wait",    {31'd0, bus.ioctl_wait}, 32'd0);
        chk("rst_target",  {30'd0, bus.dn_target},  32'd0);
        chk("rst_addr",    {15'd0, bus.dn_addr},    32'd0);
        chk("rst_data",    {24'd0, bus.dn_data},    32'd0);
        chk("rst_done",    {31'd0, done},           32'd0);
        chk("rst_didx",    {24'd0, done_index},     32'd0);
        chk("rst_bytes",   {14'd0, bytes_loaded},   32'd0);
        chk("rst_rerr",    {31'd0, range_err},      32'd0);
        chk("rst_oerr",    {31'd0, overrun_err},    32'd0);
        chk("rst_corerst", {31'd0, core_reset},     32'd1);
        reset = 1'b0;
        tick();
        chk("rel_corerst", {31'd0, core_reset}, 32'd0);

        // BIOS download, ready tied high
        bus.dn_ready       = 1'b1;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_download = 1'b1;
        tick();
        chk("bios_corerst_start", {31'd0, core_reset}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            push(2'd0, 17'(i), 8'hA0 + 8'(i));
            wr_byte(25'(i), 8'hA0 + 8'(i));
            chk("bios_valid", {31'd0, bus.dn_valid}, 32'd1);
            tick();
            chk("bios_corerst", {31'd0, core_reset}, 32'd1);
        end
        bus.ioctl_download = 1'b0;
        tick();
        chk("bios_done",  {31'd0, done},         32'd1);
        chk("bios_bytes", {14'd0, bytes_loaded}, 32'd4);
        chk("bios_didx",  {24'd0, done_index},   32'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("bios_hold", {31'd0, core_reset}, 32'd1);
        end
        tick();
        chk("bios_hold_end", {31'd0, core_reset}, 32'd0);
        chk("bios_done_cnt", done_cnt, 32'd1);

        // Music download with back-pressure and an overrun byte
        bus.dn_ready       = 1'b0;
        bus.ioctl_index    = 8'd4;
        bus.ioctl_download = 1'b1;
        tick();
        push(2'd2, 17'h12345, 8'h5A);
        wr_byte(25'h12345, 8'h5A);
        for (int c = 0; c < 5; c++) begin
            chk("bp_wait", {31'd0, bus.ioctl_wait}, 32'd1);
            chk("bp_addr", {15'd0, bus.dn_addr},    32'h12345);
            chk("bp_data", {24'd0, bus.dn_data},    32'h5A);
            bus.ioctl_wr   = (c == 1);
            bus.ioctl_addr = 25'd7;
            bus.ioctl_dout = 8'h77;
            tick();
        end
        bus.ioctl_wr = 1'b0;
        chk("bp_overrun", {31'd0, overrun_err}, 32'd1);
        chk("bp_addr_hold", {15'd0, bus.dn_addr}, 32'h12345);
        bus.dn_ready = 1'b1;
        tick();
        chk("bp_valid_low", {31'd0, bus.dn_valid}, 32'd0);
        bus.ioctl_download = 1'b0;
        tick();
        chk("bp_done",    {31'd0, done},         32'd1);
        chk("bp_bytes",   {14'd0, bytes_loaded}, 32'd1);
        chk("bp_didx",    {24'd0, done_index},   32'd4);
        chk("bp_corerst", {31'd0, core_reset},   32'd0);
        tick();

        // Sprite range check
        bus.ioctl_index    = 8'd3;
        bus.ioctl_download = 1'b1;
        tick();
        chk("spr_oerr_clr", {31'd0, overrun_err}, 32'd0);
        push(2'd1, 17'h3FFF, 8'h11);
        wr_byte(25'h3FFF, 8'h11);
        tick();
        wr_byte(25'h4000, 8'h22);
        chk("spr_rerr",  {31'd0, range_err},    32'd1);
        chk("spr_valid", {31'd0, bus.dn_valid}, 32'd0);
        bus.ioctl_download = 1'b0;
        tick();
        chk("spr_done",  {31'd0, done},         32'd1);
        chk("spr_bytes", {14'd0, bytes_loaded}, 32'd1);
        tick();

        // Unknown index: bytes consumed, nothing written
        bus.ioctl_index    = 8'd7;
        bus.ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            wr_byte(25'(i), 8'(i));
            chk("none_valid", {31'd0, bus.dn_valid}, 32'd0);
        end
        bus.ioctl_download = 1'b0;
        tick();
        chk("none_done",  {31'd0, done},         32'd1);
        chk("none_didx",  {24'd0, done_index},   32'd7);
        chk("none_bytes", {14'd0, bytes_loaded}, 32'd0);
        chk("none_rerr",  {31'd0, range_err},    32'd0);
        tick();

        // Music download closing with a write pending
        bus.dn_ready       = 1'b0;
        bus.ioctl_index    = 8'd4;
        bus.ioctl_download = 1'b1;
        tick();
        push(2'd2, 17'h10, 8'hC3);
        wr_byte(25'h10, 8'hC3);
        bus.ioctl_download = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("fl_wait",    {31'd0, bus.ioctl_wait}, 32'd1);
            chk("fl_nodone",  {31'd0, done},           32'd0);
            chk("fl_corerst", {31'd0, core_reset},     32'd0);
            tick();
        end
        bus.dn_ready = 1'b1;
        chk("fl_done_early", {31'd0, done}, 32'd0);
        tick();
        chk("fl_done",    {31'd0, done},         32'd1);
        chk("fl_bytes",   {14'd0, bytes_loaded}, 32'd1);
        chk("fl_valid",   {31'd0, bus.dn_valid}, 32'd0);
        chk("fl_corerst2",{31'd0, core_reset},   32'd0);
        tick();
        chk("fl_done_one", {31'd0, done}, 32'd0);

        // Reset mid-BIOS download with a write pending
        bus.dn_ready       = 1'b0;
        bus.ioctl_index    = 8'd1;
        bus.ioctl_download = 1'b1;
        tick();
        wr_byte(25'd5, 8'h99);
        chk("ab_valid",   {31'd0, bus.dn_valid}, 32'd1);
        chk("ab_corerst", {31'd0, core_reset},   32'd1);
        dc    = done_cnt;
        reset = 1'b1;
        #1;
        chk("ab_valid_rst",   {31'd0, bus.dn_valid},   32'd0);
        chk("ab_wait_rst",    {31'd0, bus.ioctl_wait}, 32'd0);
        chk("ab_corerst_rst", {31'd0, core_reset},     32'd1);
        chk("ab_addr_rst",    {15'd0, bus.dn_addr},    32'd0);
        bus.ioctl_download = 1'b0;
        bus.dn_ready       = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("ab_no_done",  done_cnt, dc);
        chk("ab_corerst_end", {31'd0, core_reset}, 32'd0);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
